// File: rtl/pwl_coe_lut_if.sv
// pwl_coe_lut_if
//  Groups the sample stream and the coefficient configuration port of pwl_coe_lut.
//  slave  : the LUT side (drives o_* signals).
//  master : the producer/consumer/software side (drives i_* signals).
//  Stream:  i_vld/o_rdy/i_dat in, o_vld/i_rdy/o_dat/o_act_coe out.
//  Config:  i_cfg_we/i_cfg_addr/i_cfg_coe shadow writes, i_cfg_swap request,
//           o_swap_pend / o_bank status.
interface pwl_coe_lut_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEG_BITS   = 3,
  parameter int COE_WIDTH  = 24
);
  logic                         i_cfg_we;
  logic [SEG_BITS-1:0]          i_cfg_addr;
  logic [COE_WIDTH-1:0]         i_cfg_coe;
  logic                         i_cfg_swap;
  logic                         o_swap_pend;
  logic                         o_bank;
  logic                         i_vld;
  logic                         o_rdy;
  logic signed [DATA_WIDTH-1:0] i_dat;
  logic                         o_vld;
  logic                         i_rdy;
  logic signed [DATA_WIDTH-1:0] o_dat;
  logic [COE_WIDTH-1:0]         o_act_coe;

  modport slave (
    input  i_cfg_we, i_cfg_addr, i_cfg_coe, i_cfg_swap, i_vld, i_dat, i_rdy,
    output o_swap_pend, o_bank, o_rdy, o_vld, o_dat, o_act_coe
  );

  modport master (
    output i_cfg_we, i_cfg_addr, i_cfg_coe, i_cfg_swap, i_vld, i_dat, i_rdy,
    input  o_swap_pend, o_bank, o_rdy, o_vld, o_dat, o_act_coe
  );
endinterface

// File: rtl/pwl_coe_lut.sv
// pwl_coe_lut
//  Piecewise-linear activation coefficient source. Each signed sample is mapped to
//  one of SEG_NUM uniform segments; the segment's packed {a,b} word from the active
//  bank is emitted alongside the sample two stages later. Software fills the shadow
//  bank at any time and requests a swap, which takes effect only once the pipeline
//  has drained so that no sample ever mixes banks.
//  Ports:
//    i_clk    clock
//    i_rst_n  async active-low reset (clears pipeline, both banks, swap FSM)
//    bus      pwl_coe_lut_if.slave: stream (i_vld/o_rdy/i_dat -> o_vld/i_rdy/
//             o_dat/o_act_coe) and config (i_cfg_we/addr/coe, i_cfg_swap,
//             o_swap_pend, o_bank)
module pwl_coe_lut #(
  parameter int COE_A_WIDTH = 8,
  parameter int COE_B_WIDTH = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SEG_NUM     = 8,
  parameter int SEG_BITS    = 3   // log2(SEG_NUM)
) (
  input logic          i_clk,
  input logic          i_rst_n,
  pwl_coe_lut_if.slave bus
);
  localparam int COE_W = COE_A_WIDTH + COE_B_WIDTH;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                       state;
  logic                         swap_pend;
  logic                         bank_sel;
  logic [COE_W-1:0]             bank_mem [2][SEG_NUM];

  logic                         vld_p1, vld_p2;
  logic signed [DATA_WIDTH-1:0] dat_p1, dat_p2;
  logic [SEG_BITS-1:0]          seg_p1;
  logic [COE_W-1:0]             coe_p2;

  logic                         s1_adv, s2_adv, accept;

  // Flipping the sign bit turns the two's-complement range into an offset-binary
  // ramp, so the top SEG_BITS give uniform segments from most negative upward.
  function automatic logic [SEG_BITS-1:0] seg_of(input logic signed [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] off;
    off = {~d[DATA_WIDTH-1], d[DATA_WIDTH-2:0]};
    return off[DATA_WIDTH-1 -: SEG_BITS];
  endfunction

  assign s2_adv = !vld_p2 || bus.i_rdy;
  assign s1_adv = !vld_p1 || s2_adv;
  assign accept = bus.i_vld && bus.o_rdy;

  // Swap FSM: the flip waits for both stages to be empty, which is what keeps
  // every in-flight sample on the bank it was looked up in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      swap_pend <= 1'b0;
      bank_sel  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.i_cfg_swap) begin
            state     <= DRAIN;
            swap_pend <= 1'b1;
          end
        end
        DRAIN: begin
          if (!vld_p1 && !vld_p2) begin
            bank_sel  <= !bank_sel;
            state     <= RUN;
            swap_pend <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          swap_pend <= 1'b0;
        end
      endcase
    end
  end

  // Writes always target the bank that is shadow before this edge; on the flip
  // edge that is the bank becoming active.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < SEG_NUM; s++)
          bank_mem[b][s] <= '0;
    end else if (bus.i_cfg_we) begin
      bank_mem[!bank_sel][bus.i_cfg_addr] <= bus.i_cfg_coe;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
      seg_p1 <= '0;
      vld_p2 <= 1'b0;
      dat_p2 <= '0;
      coe_p2 <= '0;
    end else begin
      // Stage 1: capture sample and its segment index
      if (s1_adv) begin
        vld_p1 <= accept;
        if (accept) begin
          dat_p1 <= bus.i_dat;
          seg_p1 <= seg_of(bus.i_dat);
        end
      end
      // Stage 2: coefficient lookup in the active bank
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          dat_p2 <= dat_p1;
          coe_p2 <= bank_mem[bank_sel][seg_p1];
        end
      end
    end
  end

  assign bus.o_rdy       = s1_adv && !swap_pend;
  assign bus.o_vld       = vld_p2;
  assign bus.o_dat       = dat_p2;
  assign bus.o_act_coe   = coe_p2;
  assign bus.o_swap_pend = swap_pend;
  assign bus.o_bank      = bank_sel;
endmodule

// File: tb/tb_pwl_coe_lut.sv
module tb_pwl_coe_lut;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pwl_coe_lut_if #(.DATA_WIDTH(8), .SEG_BITS(3), .COE_WIDTH(24)) bus ();

  pwl_coe_lut #(
    .COE_A_WIDTH(8), .COE_B_WIDTH(16), .DATA_WIDTH(8), .SEG_NUM(8), .SEG_BITS(3)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // bank pattern used by the mapping test: a=k+1, b=100*k
  function automatic logic [23:0] coe1(input int k);
    logic [7:0]  a;
    logic [15:0] b;
    a = 8'(k + 1);
    b = 16'(100 * k);
    return {a, b};
  endfunction

  function automatic logic [23:0] coe2(input int k);
    return 24'hA00000 | 24'(k);
  endfunction

  // independent segment model: shift range to 0..255, 32 codes per segment
  function automatic int segm(input int d);
    return (d + 128) / 32;
  endfunction

  task automatic wr(input int addr, input logic [23:0] coe);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_addr = 3'(addr);
    bus.i_cfg_coe  = coe;
    cyc();
    bus.i_cfg_we   = 1'b0;
  endtask

  task automatic swap_idle(input logic old_bank);
    bus.i_cfg_swap = 1'b1;
    cyc();
    bus.i_cfg_swap = 1'b0;
    chk("swap_pend_set", 32'(bus.o_swap_pend), 32'd1);
    chk("swap_rdy_low", 32'(bus.o_rdy), 32'd0);
    chk("swap_bank_hold", 32'(bus.o_bank), 32'(old_bank));
    cyc();
    chk("swap_bank_flip", 32'(bus.o_bank), 32'(!old_bank));
    chk("swap_pend_clr", 32'(bus.o_swap_pend), 32'd0);
  endtask

  logic signed [7:0] samp [65];
  logic signed [7:0] tp   [9];
  logic signed [7:0] mv   [4];
  int                ms   [4];
  logic [31:0]       held;
  logic              stall, acc, dlv;
  int                n_sent, n_recv, budget;

  initial begin
    bus.i_cfg_we = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_coe = '0; bus.i_cfg_swap = 1'b0;
    bus.i_vld = 1'b0; bus.i_dat = '0; bus.i_rdy = 1'b1;

    // reset state
    repeat (3) cyc();
    chk("rst_vld", 32'(bus.o_vld), 32'd0);
    chk("rst_bank", 32'(bus.o_bank), 32'd0);
    chk("rst_pend", 32'(bus.o_swap_pend), 32'd0);
    chk("rst_coe", 32'(bus.o_act_coe), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rdy_after_rst", 32'(bus.o_rdy), 32'd1);

    // mapping: fill shadow bank1, swap, probe segment boundaries
    for (int k = 0; k < 8; k++) wr(k, coe1(k));
    swap_idle(1'b0);
    mv[0] = -8'sd128; mv[1] = -8'sd1; mv[2] = 8'sd0; mv[3] = 8'sd127;
    ms[0] = 0; ms[1] = 3; ms[2] = 4; ms[3] = 7;
    for (int i = 0; i < 4; i++) begin
      bus.i_vld = 1'b1; bus.i_dat = mv[i];
      cyc();
      bus.i_vld = 1'b0;
      chk("map_lat1_vld", 32'(bus.o_vld), 32'd0);
      cyc();
      chk("map_lat2_vld", 32'(bus.o_vld), 32'd1);
      chk("map_out", {bus.o_dat, bus.o_act_coe}, {mv[i], coe1(ms[i])});
    end
    cyc();

    // random throughput with backpressure
    for (int i = 0; i < 65; i++) samp[i] = 8'($urandom_range(0, 255));
    n_sent = 0; n_recv = 0; budget = 0; stall = 1'b0; held = '0;
    while (n_recv < 64 && budget < 2000) begin
      bus.i_vld = (n_sent < 64) && ($urandom_range(0, 3) != 0);
      bus.i_dat = samp[n_sent];
      bus.i_rdy = ($urandom_range(0, 2) != 0);
      #1;
      acc   = bus.i_vld && bus.o_rdy;
      dlv   = bus.o_vld && bus.i_rdy;
      stall = bus.o_vld && !bus.i_rdy;
      held  = {bus.o_dat, bus.o_act_coe};
      if (dlv) begin
        chk("bp_out", {bus.o_dat, bus.o_act_coe},
            {samp[n_recv], coe1(segm(int'(samp[n_recv])))});
        n_recv++;
      end
      if (acc) n_sent++;
      cyc();
      budget++;
      if (stall) begin
        chk("bp_hold_vld", 32'(bus.o_vld), 32'd1);
        chk("bp_hold_dat", {bus.o_dat, bus.o_act_coe}, held);
      end
    end
    chk("bp_count", 32'(n_recv), 32'd64);
    bus.i_vld = 1'b0; bus.i_rdy = 1'b1;
    repeat (3) cyc();

    // full throughput with i_rdy=1
    tp[0] = 8'sd10; tp[1] = -8'sd20; tp[2] = 8'sd33; tp[3] = -8'sd128;
    tp[4] = 8'sd127; tp[5] = 8'sd64; tp[6] = -8'sd65; tp[7] = 8'sd0; tp[8] = 8'sd0;
    for (int i = 0; i < 9; i++) begin
      bus.i_vld = (i < 8); bus.i_dat = tp[i];
      #1;
      if (i < 8) chk("tp_rdy", 32'(bus.o_rdy), 32'd1);
      cyc();
      if (i >= 1) begin
        chk("tp_vld", 32'(bus.o_vld), 32'd1);
        chk("tp_out", {bus.o_dat, bus.o_act_coe}, {tp[i-1], coe1(segm(int'(tp[i-1])))});
      end
    end
    bus.i_vld = 1'b0;
    repeat (3) cyc();

    // swap drain with two samples in flight (bank1 -> bank0)
    for (int k = 0; k < 8; k++) wr(k, coe2(k));
    bus.i_vld = 1'b1; bus.i_dat = 8'sd40;     // seg 5
    cyc();
    bus.i_dat = -8'sd100;                     // seg 0
    cyc();
    chk("drain_old0", {bus.o_dat, bus.o_act_coe}, {8'sd40, coe1(5)});
    bus.i_vld = 1'b0; bus.i_cfg_swap = 1'b1;
    cyc();
    bus.i_cfg_swap = 1'b0;
    chk("drain_pend", 32'(bus.o_swap_pend), 32'd1);
    chk("drain_old1", {bus.o_dat, bus.o_act_coe}, {-8'sd100, coe1(0)});
    bus.i_vld = 1'b1; bus.i_dat = 8'sd100;    // seg 7
    #1;
    chk("drain_rdy0", 32'(bus.o_rdy), 32'd0);
    cyc();
    chk("drain_bank_hold", 32'(bus.o_bank), 32'd1);
    chk("drain_rdy1", 32'(bus.o_rdy), 32'd0);
    cyc();
    chk("drain_flip", 32'(bus.o_bank), 32'd0);
    chk("drain_pend_clr", 32'(bus.o_swap_pend), 32'd0);
    chk("drain_rdy_back", 32'(bus.o_rdy), 32'd1);
    cyc();
    bus.i_vld = 1'b0;
    cyc();
    chk("drain_new", {bus.o_dat, bus.o_act_coe}, {8'sd100, coe2(7)});
    repeat (3) cyc();

    // shadow isolation: write bank1 seg 4 while streaming zeros on bank0
    bus.i_vld = 1'b1; bus.i_dat = 8'sd0;
    cyc(); cyc();
    wr(4, 24'hFFFFFF);
    chk("iso_before0", 32'(bus.o_act_coe), 32'(coe2(4)));
    cyc();
    chk("iso_before1", 32'(bus.o_act_coe), 32'(coe2(4)));
    bus.i_cfg_swap = 1'b1;
    cyc();
    bus.i_cfg_swap = 1'b0;
    budget = 0;
    while (bus.o_bank !== 1'b1 && budget < 10) begin
      chk("iso_drain_old", 32'(bus.o_act_coe), 32'(coe2(4)));
      cyc();
      budget++;
    end
    chk("iso_flipped", 32'(bus.o_bank), 32'd1);
    cyc(); cyc();
    chk("iso_after_vld", 32'(bus.o_vld), 32'd1);
    chk("iso_after", 32'(bus.o_act_coe), 32'hFFFFFF);
    bus.i_vld = 1'b0;
    repeat (3) cyc();

    // repeated swap during a stalled drain, write on the flip edge
    bus.i_rdy = 1'b0; bus.i_vld = 1'b1; bus.i_dat = 8'sd0;
    cyc(); cyc();
    bus.i_vld = 1'b0; bus.i_cfg_swap = 1'b1;
    cyc();
    chk("dbl_pend", 32'(bus.o_swap_pend), 32'd1);
    cyc();
    chk("dbl_bank_a", 32'(bus.o_bank), 32'd1);
    cyc();
    chk("dbl_bank_b", 32'(bus.o_bank), 32'd1);
    bus.i_cfg_swap = 1'b0; bus.i_rdy = 1'b1;
    cyc();
    chk("dbl_bank_c", 32'(bus.o_bank), 32'd1);
    cyc();
    chk("dbl_bank_d", 32'(bus.o_bank), 32'd1);
    chk("dbl_pend_d", 32'(bus.o_swap_pend), 32'd1);
    wr(2, 24'h123456);
    chk("dbl_flip", 32'(bus.o_bank), 32'd0);
    chk("dbl_pend_clr", 32'(bus.o_swap_pend), 32'd0);
    repeat (3) cyc();
    chk("dbl_single_flip", 32'(bus.o_bank), 32'd0);
    bus.i_vld = 1'b1; bus.i_dat = -8'sd64;    // seg 2
    cyc();
    bus.i_vld = 1'b0;
    cyc();
    chk("flip_write", {bus.o_dat, bus.o_act_coe}, {-8'sd64, 24'h123456});
    repeat (2) cyc();

    // reset mid-stream
    swap_idle(1'b0);
    bus.i_vld = 1'b1; bus.i_dat = 8'sd5;
    cyc(); cyc();
    chk("pre_rst_vld", 32'(bus.o_vld), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.o_vld), 32'd0);
    chk("mid_rst_bank", 32'(bus.o_bank), 32'd0);
    chk("mid_rst_pend", 32'(bus.o_swap_pend), 32'd0);
    chk("mid_rst_out", {bus.o_dat, bus.o_act_coe}, 32'd0);
    bus.i_vld = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.i_vld = 1'b1; bus.i_dat = 8'sd0;
    cyc();
    bus.i_vld = 1'b0;
    cyc();
    chk("post_rst_vld", 32'(bus.o_vld), 32'd1);
    chk("post_rst_cleared", 32'(bus.o_act_coe), 32'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
